// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 stream generator: FSM states, default
// frame geometry and the RGB444 -> RGB565 packing used on the byte stream.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_e;

    localparam int DEF_H_ACTIVE  = 320;
    localparam int DEF_V_ACTIVE  = 240;
    localparam int DEF_H_BLANK   = 144;
    localparam int DEF_VS_LINES  = 3;
    localparam int DEF_VBP_LINES = 17;
    localparam int DEF_VFP_LINES = 10;

    // Each 4-bit channel lands in the MSBs of its 565 field; the low bits are zero.
    function automatic logic [15:0] rgb444_to_565(input logic [11:0] px);
        return {px[11:8], 1'b0, px[7:4], 2'b00, px[3:0], 1'b0};
    endfunction

endpackage

// File: rtl/ov7670_timing_gen.sv
// Frame/line sequencer: column and line counters, frame FSM and the registered
// vsync / href / frame_done / pixel-fetch strobes.
module ov7670_timing_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VS_LINES  = DEF_VS_LINES,
    parameter int VBP_LINES = DEF_VBP_LINES,
    parameter int VFP_LINES = DEF_VFP_LINES
) (
    input  logic   pclk,
    input  logic   rst,
    input  logic   en,
    output state_e state_o,
    output state_e state_nxt_o,
    output logic   href_nxt_o,
    output logic   odd_nxt_o,
    output logic   vsync_o,
    output logic   href_o,
    output logic   frame_done_o,
    output logic   fetch_o
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W    = $clog2(LINE_LEN);
    localparam int LINE_W   = $clog2(VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   last_line;
    logic                line_end, state_end;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic                done_q, done_d;
    logic                fetch_q, fetch_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        last_line = '0;
        case (state_q)
            ST_VSYNC:  last_line = LINE_W'(VS_LINES - 1);
            ST_VBP:    last_line = LINE_W'(VBP_LINES - 1);
            ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
            ST_VFP:    last_line = LINE_W'(VFP_LINES - 1);
            default:   last_line = '0;
        endcase
        line_end  = (col_q == COL_W'(LINE_LEN - 1));
        state_end = line_end && (line_q == last_line);

        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (en) state_d = ST_VSYNC;
        end else begin
            col_d = line_end ? '0 : col_q + COL_W'(1);
            if (line_end) line_d = state_end ? '0 : line_q + LINE_W'(1);
            if (state_end) begin
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBP;
                    ST_VBP:    state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFP;
                    ST_VFP:    state_d = en ? ST_VSYNC : ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from the next-cycle position so they register in
    // step with the counters. A fetch runs two cycles ahead of its byte0 column;
    // the first pixel of each line is fetched in the preceding line's blanking.
    always_comb begin
        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE) && (col_d < COL_W'(2 * H_ACTIVE));
        done_d  = (state_d == ST_VFP) && (line_d == LINE_W'(VFP_LINES - 1))
                  && (col_d == COL_W'(LINE_LEN - 1));
        fetch_d = ((state_d == ST_ACTIVE) && !col_d[0] && (col_d < COL_W'(2 * H_ACTIVE - 2)))
                  || ((col_d == COL_W'(LINE_LEN - 2))
                      && (((state_d == ST_VBP) && (line_d == LINE_W'(VBP_LINES - 1)))
                          || ((state_d == ST_ACTIVE) && (line_d < LINE_W'(V_ACTIVE - 1)))));
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
            fetch_q <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            done_q  <= done_d;
            fetch_q <= fetch_d;
        end
    end

    assign state_o      = state_q;
    assign state_nxt_o  = state_d;
    assign href_nxt_o   = href_d;
    assign odd_nxt_o    = col_d[0];
    assign vsync_o      = vsync_q;
    assign href_o       = href_q;
    assign frame_done_o = done_q;
    assign fetch_o      = fetch_q;

endmodule

// File: rtl/ov7670_stream_gen.sv
// Replays a RGB444 frame buffer as an OV7670-style vsync/href/byte stream:
// timing from ov7670_timing_gen, plus read address, pixel pipeline and byte mux.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VS_LINES  = DEF_VS_LINES,
    parameter int VBP_LINES = DEF_VBP_LINES,
    parameter int VFP_LINES = DEF_VFP_LINES
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [16:0] rd_addr,
    output logic        rd_en,
    input  logic [11:0] rd_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done
);

    localparam logic [16:0] ADDR_MAX = 17'(H_ACTIVE * V_ACTIVE - 1);

    state_e      tg_state, tg_state_nxt;
    logic        href_nxt, odd_nxt, fetch;
    logic        frame_start;
    logic [15:0] word_in;
    logic [16:0] addr_q, addr_d;
    logic        rd_vld_q, rd_vld_d;
    logic [7:0]  pix_lo_q, pix_lo_d;
    logic [7:0]  d_q, d_d;

    ov7670_timing_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .H_BLANK   (H_BLANK),
        .VS_LINES  (VS_LINES),
        .VBP_LINES (VBP_LINES),
        .VFP_LINES (VFP_LINES)
    ) u_timing (
        .pclk         (pclk),
        .rst          (rst),
        .en           (en),
        .state_o      (tg_state),
        .state_nxt_o  (tg_state_nxt),
        .href_nxt_o   (href_nxt),
        .odd_nxt_o    (odd_nxt),
        .vsync_o      (vsync),
        .href_o       (href),
        .frame_done_o (frame_done),
        .fetch_o      (fetch)
    );

    assign frame_start = (tg_state_nxt == ST_VSYNC) && (tg_state != ST_VSYNC);
    assign word_in     = rgb444_to_565(rd_data);

    // rd_data is valid the cycle after a fetch: byte0 goes straight to d while
    // the low byte is parked for the following odd column.
    always_comb begin
        addr_d = addr_q;
        if (frame_start) begin
            addr_d = '0;
        end else if (fetch && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + 17'd1;
        end
        rd_vld_d = fetch;
        pix_lo_d = rd_vld_q ? word_in[7:0] : pix_lo_q;
        d_d      = 8'h00;
        if (href_nxt) d_d = odd_nxt ? pix_lo_q : word_in[15:8];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            addr_q   <= '0;
            rd_vld_q <= 1'b0;
            pix_lo_q <= '0;
            d_q      <= '0;
        end else begin
            addr_q   <= addr_d;
            rd_vld_q <= rd_vld_d;
            pix_lo_q <= pix_lo_d;
            d_q      <= d_d;
        end
    end

    assign rd_addr = addr_q;
    assign rd_en   = fetch;
    assign d       = d_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen at a reduced 4x3 geometry with a behavioural
// frame model built from the pixel timing rules and a capture-side reassembly.
module tb_ov7670_stream_gen;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int HB    = 4;
    localparam int VS    = 1;
    localparam int VBP   = 1;
    localparam int VFP   = 1;
    localparam int LL    = 2 * H + HB;
    localparam int FRAME = (VS + VBP + V + VFP) * LL;
    localparam int NPIX  = H * V;
    localparam int MAXA  = NPIX - 1;
    localparam int ACT0  = (VS + VBP) * LL;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [11:0] rd_data = 12'h000;
    logic        vsync, href, frame_done;
    logic [7:0]  d;

    int n_vec  = 0;
    int n_miss = 0;

    logic [11:0] mem [NPIX];
    logic [7:0]  first_bytes [4];
    logic        exp_vs [FRAME];
    logic        exp_hr [FRAME];
    logic        exp_re [FRAME];
    logic        exp_fd [FRAME];
    logic [7:0]  exp_d  [FRAME];
    logic [16:0] exp_a  [FRAME];

    always #5 pclk = ~pclk;

    ov7670_stream_gen #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .H_BLANK   (HB),
        .VS_LINES  (VS),
        .VBP_LINES (VBP),
        .VFP_LINES (VFP)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .frame_done (frame_done)
    );

    // Synchronous frame-buffer model: data one cycle after the read strobe.
    always @(posedge pclk) begin
        if (rd_en && (int'(rd_addr) < NPIX)) rd_data <= mem[int'(rd_addr)];
    end

    function automatic logic [15:0] to565(input logic [11:0] px);
        int r, g, b;
        r = int'(px[11:8]);
        g = int'(px[7:4]);
        b = int'(px[3:0]);
        return 16'((r * 2) * 2048 + (g * 4) * 32 + (b * 2));
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom_range(0, 4095));
    endtask

    // Expected per-cycle outputs, placed pixel by pixel from the frame rules.
    task automatic build_model();
        int b0;
        int cnt;
        for (int n = 0; n < FRAME; n++) begin
            exp_vs[n] = (n < VS * LL);
            exp_fd[n] = (n == FRAME - 1);
            exp_hr[n] = 1'b0;
            exp_re[n] = 1'b0;
            exp_d[n]  = 8'h00;
        end
        for (int p = 0; p < NPIX; p++) begin
            b0 = (VS + VBP + p / H) * LL + 2 * (p % H);
            exp_hr[b0]     = 1'b1;
            exp_hr[b0 + 1] = 1'b1;
            exp_d[b0]      = to565(mem[p]) / 256;
            exp_d[b0 + 1]  = to565(mem[p]) % 256;
            exp_re[b0 - 2] = 1'b1;
        end
        cnt = 0;
        for (int n = 0; n < FRAME; n++) begin
            exp_a[n] = 17'((cnt > MAXA) ? MAXA : cnt);
            if (exp_re[n]) cnt++;
        end
    endtask

    // Starts at the sampling point of frame cycle 0 and checks ncyc cycles.
    task automatic check_frame(input int ncyc, input bit next_en, input bit rand_en);
        int          fetches;
        int          bytes;
        int          cap;
        logic [7:0]  hi;
        logic [15:0] w;
        logic [11:0] px;
        logic [28:0] obs, expv;
        fetches = 0;
        bytes   = 0;
        cap     = 0;
        hi      = 8'h00;
        build_model();
        for (int n = 0; n < ncyc; n++) begin
            obs  = {vsync, href, d, rd_en, frame_done, rd_addr};
            expv = {exp_vs[n], exp_hr[n], exp_d[n], exp_re[n], exp_fd[n], exp_a[n]};
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL frame_cycle n=%0d got vs=%b href=%b d=%h rd_en=%b done=%b addr=%0d, exp vs=%b href=%b d=%h rd_en=%b done=%b addr=%0d",
                         n, vsync, href, d, rd_en, frame_done, rd_addr,
                         exp_vs[n], exp_hr[n], exp_d[n], exp_re[n], exp_fd[n], exp_a[n]);
            end
            if (rd_en === 1'b1) fetches++;
            if ((n >= ACT0) && (n < ACT0 + 4)) first_bytes[n - ACT0] = d;
            if (href === 1'b1) begin
                if (bytes % 2 == 0) begin
                    hi = d;
                end else if (cap < NPIX) begin
                    w  = {hi, d};
                    px = {w[15:12], w[10:7], w[4:1]};
                    n_vec++;
                    if (px !== mem[cap]) begin
                        n_miss++;
                        $display("FAIL loopback pixel=%0d got %h exp %h", cap, px, mem[cap]);
                    end
                    cap++;
                end
                bytes++;
            end
            if (rand_en) en = 1'($urandom_range(0, 1));
            if (n == FRAME - 1) en = next_en;
            @(negedge pclk);
        end
        if (ncyc == FRAME) begin
            n_vec++;
            if (fetches != NPIX) begin
                n_miss++;
                $display("FAIL rd_en_count got %0d exp %0d", fetches, NPIX);
            end
            n_vec++;
            if (cap != NPIX) begin
                n_miss++;
                $display("FAIL captured_pixels got %0d exp %0d", cap, NPIX);
            end
        end
    endtask

    task automatic check_idle(input int ncyc, input logic [16:0] addr);
        logic [28:0] obs, expv;
        for (int n = 0; n < ncyc; n++) begin
            obs  = {vsync, href, d, rd_en, frame_done, rd_addr};
            expv = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, addr};
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL idle n=%0d got vs=%b href=%b d=%h rd_en=%b done=%b addr=%0d, exp all 0 addr=%0d",
                         n, vsync, href, d, rd_en, frame_done, rd_addr, addr);
            end
            @(negedge pclk);
        end
    endtask

    task automatic test_reset();
        fill_mem();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            n_vec++;
            if ({vsync, href, d, rd_en, frame_done, rd_addr} !== 29'd0) begin
                n_miss++;
                $display("FAIL reset_outputs got vs=%b href=%b d=%h rd_en=%b done=%b addr=%0d exp all 0",
                         vsync, href, d, rd_en, frame_done, rd_addr);
            end
        end
        rst = 1'b0;
        @(negedge pclk);
        n_vec++;
        if (vsync !== 1'b1) begin
            n_miss++;
            $display("FAIL vsync_after_rst got %b exp 1", vsync);
        end
        en = 1'b0;
        check_frame(FRAME, 1'b0, 1'b0);
        check_idle(5, 17'(MAXA));
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b [4];
        fill_mem();
        mem[0] = 12'hF0A;
        mem[1] = 12'hFFF;
        exp_b[0] = 8'hF0;
        exp_b[1] = 8'h14;
        exp_b[2] = 8'hF7;
        exp_b[3] = 8'h9E;
        en = 1'b1;
        @(negedge pclk);
        en = 1'b0;
        check_frame(FRAME, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (first_bytes[i] !== exp_b[i]) begin
                n_miss++;
                $display("FAIL first_line_byte%0d got %h exp %h", i, first_bytes[i], exp_b[i]);
            end
        end
        check_idle(6, 17'(MAXA));
    endtask

    task automatic test_back_to_back();
        fill_mem();
        en = 1'b1;
        @(negedge pclk);
        check_frame(FRAME, 1'b1, 1'b0);
        check_frame(FRAME, 1'b0, 1'b1);
        check_idle(5, 17'(MAXA));
    endtask

    task automatic test_mid_line_reset();
        int line;
        fill_mem();
        line = $urandom_range(0, V - 1);
        en = 1'b1;
        @(negedge pclk);
        en = 1'b0;
        check_frame(ACT0 + line * LL + 5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge pclk);
        check_idle(1, 17'd0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge pclk);
        en = 1'b0;
        check_frame(FRAME, 1'b0, 1'b1);
        check_idle(4, 17'(MAXA));
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_mid_line_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
